calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer_pkg.sv | 56 +++++
 rtl/calc_sequencer_if.sv | 25 ++
 rtl/calc_sequencer_entry_buffer.sv | 56 +++++
 rtl/calc_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator key sequencer and its arithmetic unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: operator codes (ADD=0 SUB=1 MUL=2 DIV=3 MOD=4), keypad key codes,
// the display error sentinel, FSM state type and operator-key helpers.
package calc_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_OP_SEL,
        ST_ENTRY_B,
        ST_WAIT_CALC,
        ST_RESULT,
        ST_ERROR
    } state_t;

    localparam logic [3:0] KEY_DIVMOD = 4'ha;
    localparam logic [3:0] KEY_MUL    = 4'hb;
    localparam logic [3:0] KEY_ADDSUB = 4'hc;
    localparam logic [3:0] KEY_AC     = 4'hd;
    localparam logic [3:0] KEY_ANS    = 4'he;
    localparam logic [3:0] KEY_EQ     = 4'hf;

    localparam logic signed [31:0] ERR_SENTINEL = 32'sh8000_0000;

    // Operator selected by the first press of an operator key.
    function automatic op_t key_base_op(input logic [3:0] key);
        op_t r;
        case (key)
            KEY_DIVMOD: r = OP_DIV;
            KEY_ADDSUB: r = OP_ADD;
            default:    r = OP_MUL;
        endcase
        return r;
    endfunction

    // Operator after a key press while already choosing an operator: pressing
    // the key that produced the current base code flips it to its alternate;
    // any other situation falls back to the key's base code.
    function automatic op_t op_after_key(input logic [3:0] key, input op_t cur);
        op_t r;
        r = key_base_op(key);
        if (key == KEY_DIVMOD && cur == OP_DIV) r = OP_MOD;
        if (key == KEY_ADDSUB && cur == OP_ADD) r = OP_SUB;
        return r;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Launch/complete handshake between the key sequencer and the arithmetic unit.
// Latency: n/a (wires only).
// Backpressure: none; calc_start is a single pulse, operands stay stable until calc_done.
// master = sequencer (drives start/operands/operator), slave = arithmetic unit.
interface calc_sequencer_if;
    import calc_sequencer_pkg::*;

    logic               calc_start;
    logic signed [31:0] operand1;
    logic signed [31:0] operand2;
    op_t                operator;
    logic               calc_done;
    logic signed [31:0] calc_result;
    logic               calc_err;

    modport master (
        output calc_start, operand1, operand2, operator,
        input  calc_done, calc_result, calc_err
    );

    modport slave (
        input  calc_start, operand1, operand2, operator,
        output calc_done, calc_result, calc_err
    );
endinterface

// File: rtl/calc_sequencer_entry_buffer.sv
// Decimal entry accumulator: value = value*10 + digit, capped at MAX_DIGITS digits.
// Latency: value updates on the sw_clk edge that samples the strobe; value_nxt is its combinational preview.
// Backpressure: none; digits beyond the limit are silently dropped.
// Ports: clear / load(load_value, marks full) / digit_vld(digit) in; value, value_nxt, full out.
module entry_buffer #(
    parameter int MAX_DIGITS = 9
) (
    input  logic               sw_clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic signed [31:0] load_value,
    input  logic               digit_vld,
    input  logic [3:0]         digit,
    output logic signed [31:0] value,
    output logic signed [31:0] value_nxt,
    output logic               full
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic signed [31:0] digit_ext;

    assign digit_ext = $signed({28'd0, digit});
    assign full      = (count >= CW'(MAX_DIGITS));

    // clear+digit together starts a fresh number with that digit.
    always_comb begin
        value_nxt = value;
        count_nxt = count;
        if (clear && digit_vld) begin
            value_nxt = digit_ext;
            count_nxt = CW'(1);
        end else if (clear) begin
            value_nxt = '0;
            count_nxt = '0;
        end else if (load) begin
            value_nxt = load_value;
            count_nxt = CW'(MAX_DIGITS);
        end else if (digit_vld && !full) begin
            value_nxt = value * 32'sd10 + digit_ext;
            count_nxt = count + CW'(1);
        end
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            count <= '0;
        end else begin
            value <= value_nxt;
            count <= count_nxt;
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: builds two operands and an operator, launches the arithmetic unit, shows results.
// Latency: fnd_serial and all control outputs are registered, one sw_clk after the causing key or calc_done.
// Backpressure: none; keys other than AC are ignored while busy or in error, AC always wins.
// Ports: sw_clk, rst (async active-low), eBCD keypad event, calc (master handshake), fnd_serial, err_flag, busy.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int MAX_DIGITS   = 9,
    parameter int CALC_TIMEOUT = 64
) (
    input  logic               sw_clk,
    input  logic               rst,
    input  logic [4:0]         eBCD,
    calc_sequencer_if.master   calc,
    output logic signed [31:0] fnd_serial,
    output logic               err_flag,
    output logic               busy
);
    localparam int TW = $clog2(CALC_TIMEOUT + 1);

    state_t             state;
    logic signed [31:0] ans;
    logic [TW-1:0]      tmo_cnt;

    logic [3:0] key;
    logic       is_digit, is_op, is_ac, is_ans, is_eq, is_addsub;
    logic       buf_clear, buf_load, buf_digit, buf_full;
    logic signed [31:0] buf_val, buf_nxt;

    assign key       = eBCD[3:0];
    assign is_digit  = eBCD[4] && (key <= 4'd9);
    assign is_op     = eBCD[4] && (key == KEY_DIVMOD || key == KEY_MUL || key == KEY_ADDSUB);
    assign is_addsub = eBCD[4] && (key == KEY_ADDSUB);
    assign is_ac     = eBCD[4] && (key == KEY_AC);
    assign is_ans    = eBCD[4] && (key == KEY_ANS);
    assign is_eq     = eBCD[4] && (key == KEY_EQ);

    // Buffer commands are decoded from the current state so the buffer and the
    // FSM move on the same edge.
    always_comb begin
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        buf_digit = 1'b0;
        if (is_ac) begin
            buf_clear = 1'b1;
        end else begin
            case (state)
                ST_ENTRY_A, ST_ENTRY_B: begin
                    buf_digit = is_digit;
                    buf_load  = is_ans;
                end
                ST_OP_SEL, ST_RESULT: begin
                    buf_clear = is_digit;
                    buf_digit = is_digit;
                end
                default: ;
            endcase
        end
    end

    entry_buffer #(.MAX_DIGITS(MAX_DIGITS)) u_entry (
        .sw_clk     (sw_clk),
        .rst        (rst),
        .clear      (buf_clear),
        .load       (buf_load),
        .load_value (ans),
        .digit_vld  (buf_digit),
        .digit      (key),
        .value      (buf_val),
        .value_nxt  (buf_nxt),
        .full       (buf_full)
    );

    // buf_full only gates digits inside the buffer; the FSM does not need it.
    logic unused_full;
    assign unused_full = buf_full;

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_ENTRY_A;
            ans             <= '0;
            tmo_cnt         <= '0;
            calc.calc_start <= 1'b0;
            calc.operand1   <= '0;
            calc.operand2   <= '0;
            calc.operator   <= OP_ADD;
            fnd_serial      <= '0;
            err_flag        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            calc.calc_start <= 1'b0;
            if (is_ac) begin
                // AC outranks a same-cycle calc_done: the result is dropped.
                state         <= ST_ENTRY_A;
                tmo_cnt       <= '0;
                calc.operand1 <= '0;
                calc.operand2 <= '0;
                calc.operator <= OP_ADD;
                fnd_serial    <= '0;
                err_flag      <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (state)
                    ST_ENTRY_A: begin
                        fnd_serial <= buf_nxt;
                        if (is_op) begin
                            calc.operand1 <= buf_val;
                            calc.operator <= key_base_op(key);
                            fnd_serial    <= buf_val;
                            state         <= ST_OP_SEL;
                        end
                    end
                    ST_OP_SEL: begin
                        if (is_op) begin
                            calc.operator <= op_after_key(key, calc.operator);
                        end else if (is_digit) begin
                            fnd_serial <= buf_nxt;
                            state      <= ST_ENTRY_B;
                        end
                    end
                    ST_ENTRY_B: begin
                        fnd_serial <= buf_nxt;
                        if (is_addsub) begin
                            calc.operator <= OP_SUB;
                        end else if (is_eq) begin
                            calc.operand2   <= buf_val;
                            calc.calc_start <= 1'b1;
                            busy            <= 1'b1;
                            tmo_cnt         <= '0;
                            state           <= ST_WAIT_CALC;
                        end
                    end
                    ST_WAIT_CALC: begin
                        // fnd_serial deliberately holds whatever was on display.
                        if (calc.calc_done) begin
                            busy <= 1'b0;
                            if (calc.calc_err) begin
                                err_flag   <= 1'b1;
                                fnd_serial <= ERR_SENTINEL;
                                state      <= ST_ERROR;
                            end else begin
                                ans        <= calc.calc_result;
                                fnd_serial <= calc.calc_result;
                                state      <= ST_RESULT;
                            end
                        end else if (tmo_cnt == TW'(CALC_TIMEOUT - 1)) begin
                            // CALC_TIMEOUT edges spent in WAIT_CALC with no answer.
                            busy       <= 1'b0;
                            err_flag   <= 1'b1;
                            fnd_serial <= ERR_SENTINEL;
                            state      <= ST_ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    ST_RESULT: begin
                        if (is_digit) begin
                            fnd_serial <= buf_nxt;
                            state      <= ST_ENTRY_A;
                        end else if (is_op) begin
                            calc.operand1 <= ans;
                            calc.operator <= key_base_op(key);
                            fnd_serial    <= ans;
                            state         <= ST_OP_SEL;
                        end
                    end
                    default: ; // ST_ERROR: only AC leaves
                endcase
            end
        end
    end
endmodule
